// File: rtl/pe_shift_pkg.sv
// Shared constants and lane-selection helpers for the segmented PE rotator.
package pe_shift_pkg;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_SHIFT  = 1'b1;

    localparam int unsigned LANE_IDX_WIDTH = 32;

    typedef struct packed {
        logic [LANE_IDX_WIDTH-1:0] lane;
        logic                      zero;
    } src_sel_t;

    function automatic int unsigned sat_group_log(input int unsigned group_log,
                                                  input int unsigned nof_levels);
        return (group_log > nof_levels) ? nof_levels : group_log;
    endfunction

    // Source lane for one level's move of 2^level; the index wraps inside the
    // group and zero marks a move that would cross the group edge.
    function automatic src_sel_t src_select(input int unsigned level,
                                            input int unsigned lane,
                                            input int unsigned group_log,
                                            input logic        dir);
        src_sel_t    sel;
        int unsigned g;
        int unsigned d;
        int unsigned j;
        int unsigned base;
        g    = 32'd1 << group_log;
        d    = 32'd1 << level;
        j    = lane & (g - 32'd1);
        base = lane - j;
        if (dir == DIR_UP) begin
            sel.lane = LANE_IDX_WIDTH'(base + ((j + g - d) & (g - 32'd1)));
            sel.zero = (j < d);
        end else begin
            sel.lane = LANE_IDX_WIDTH'(base + ((j + d) & (g - 32'd1)));
            sel.zero = ((j + d) >= g);
        end
        return sel;
    endfunction

endpackage

// File: rtl/pe_rotator_stage.sv
// One shift level: conditional move by 2^LEVEL plus its pipeline register.
module pe_rotator_stage #(
    parameter int unsigned WORD_SIZE        = 256,
    parameter int unsigned NOF_PES          = 16,
    parameter int unsigned NOF_LEVELS       = $clog2(NOF_PES),
    parameter int unsigned GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int unsigned TAG_WIDTH        = 8,
    parameter int unsigned LEVEL            = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          up_valid,
    output logic                          up_ready_c,
    input  logic [WORD_SIZE*NOF_PES-1:0]  up_data,
    input  logic [NOF_LEVELS-1:0]         up_amt,
    input  logic [GROUP_SIZE_WIDTH-1:0]   up_group_log,
    input  logic                          up_dir,
    input  logic                          up_mode,
    input  logic [TAG_WIDTH-1:0]          up_tag,
    input  logic                          dn_ready,
    output logic                          dn_valid,
    output logic [WORD_SIZE*NOF_PES-1:0]  dn_data,
    output logic [NOF_LEVELS-1:0]         dn_amt,
    output logic [GROUP_SIZE_WIDTH-1:0]   dn_group_log,
    output logic                          dn_dir,
    output logic                          dn_mode,
    output logic [TAG_WIDTH-1:0]          dn_tag
);
    import pe_shift_pkg::*;

    localparam int unsigned DATA_WIDTH = WORD_SIZE * NOF_PES;

    int unsigned           g_log;
    logic [NOF_LEVELS-1:0] eff_amt;
    logic [DATA_WIDTH-1:0] moved;
    src_sel_t              sel;

    // Saturation and masking are idempotent, so every stage reapplies them.
    always_comb begin
        g_log   = sat_group_log(32'(up_group_log), NOF_LEVELS);
        eff_amt = up_amt & NOF_LEVELS'((32'd1 << g_log) - 32'd1);
        moved   = up_data;
        sel     = '0;
        if (eff_amt[LEVEL]) begin
            for (int unsigned p = 0; p < NOF_PES; p++) begin
                sel = src_select(LEVEL, p, g_log, up_dir);
                if (up_mode == MODE_SHIFT && sel.zero) begin
                    moved[p*WORD_SIZE +: WORD_SIZE] = '0;
                end else begin
                    moved[p*WORD_SIZE +: WORD_SIZE] = up_data[sel.lane*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    // Load when empty or when the next stage drains us; held low in reset.
    assign up_ready_c = rst_n & (~dn_valid | dn_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid     <= 1'b0;
            dn_data      <= '0;
            dn_amt       <= '0;
            dn_group_log <= '0;
            dn_dir       <= 1'b0;
            dn_mode      <= 1'b0;
            dn_tag       <= '0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data      <= moved;
                dn_amt       <= eff_amt;
                dn_group_log <= GROUP_SIZE_WIDTH'(g_log);
                dn_dir       <= up_dir;
                dn_mode      <= up_mode;
                dn_tag       <= up_tag;
            end
        end
    end

endmodule

// File: rtl/pe_segmented_rotator.sv
// Pipelined segmented rotator/shifter across PE lanes, one stage per shift level.
module pe_segmented_rotator #(
    parameter int unsigned WORD_SIZE        = 256,
    parameter int unsigned NOF_PES          = 16,
    parameter int unsigned NOF_LEVELS       = $clog2(NOF_PES),
    parameter int unsigned GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int unsigned TAG_WIDTH        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_SIZE*NOF_PES-1:0]  in,
    input  logic [NOF_LEVELS-1:0]         in_amt,
    input  logic [GROUP_SIZE_WIDTH-1:0]   in_group_log,
    input  logic                          in_dir,
    input  logic                          in_mode,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_SIZE*NOF_PES-1:0]  out,
    output logic [TAG_WIDTH-1:0]          out_tag
);
    import pe_shift_pkg::*;

    localparam int unsigned DATA_WIDTH = WORD_SIZE * NOF_PES;

    logic [NOF_LEVELS:0]         valid_chain;
    logic [NOF_LEVELS:0]         ready_chain;
    logic [DATA_WIDTH-1:0]       data_chain      [NOF_LEVELS+1];
    logic [NOF_LEVELS-1:0]       amt_chain       [NOF_LEVELS+1];
    logic [GROUP_SIZE_WIDTH-1:0] group_log_chain [NOF_LEVELS+1];
    logic [NOF_LEVELS:0]         dir_chain;
    logic [NOF_LEVELS:0]         mode_chain;
    logic [TAG_WIDTH-1:0]        tag_chain       [NOF_LEVELS+1];
    logic                        unused_ctrl;

    assign valid_chain[0]     = in_valid;
    assign data_chain[0]      = in;
    assign amt_chain[0]       = in_amt;
    assign group_log_chain[0] = in_group_log;
    assign dir_chain[0]       = in_dir;
    assign mode_chain[0]      = in_mode;
    assign tag_chain[0]       = in_tag;

    assign ready_chain[NOF_LEVELS] = out_ready;
    assign in_ready                = ready_chain[0];

    for (genvar s = 0; s < NOF_LEVELS; s++) begin : g_stage
        pe_rotator_stage #(
            .WORD_SIZE        (WORD_SIZE),
            .NOF_PES          (NOF_PES),
            .NOF_LEVELS       (NOF_LEVELS),
            .GROUP_SIZE_WIDTH (GROUP_SIZE_WIDTH),
            .TAG_WIDTH        (TAG_WIDTH),
            .LEVEL            (s)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .up_valid     (valid_chain[s]),
            .up_ready_c   (ready_chain[s]),
            .up_data      (data_chain[s]),
            .up_amt       (amt_chain[s]),
            .up_group_log (group_log_chain[s]),
            .up_dir       (dir_chain[s]),
            .up_mode      (mode_chain[s]),
            .up_tag       (tag_chain[s]),
            .dn_ready     (ready_chain[s+1]),
            .dn_valid     (valid_chain[s+1]),
            .dn_data      (data_chain[s+1]),
            .dn_amt       (amt_chain[s+1]),
            .dn_group_log (group_log_chain[s+1]),
            .dn_dir       (dir_chain[s+1]),
            .dn_mode      (mode_chain[s+1]),
            .dn_tag       (tag_chain[s+1])
        );
    end

    assign out_valid = valid_chain[NOF_LEVELS];
    assign out       = data_chain[NOF_LEVELS];
    assign out_tag   = tag_chain[NOF_LEVELS];

    // Control fields past the final level have no consumer.
    assign unused_ctrl = ^{amt_chain[NOF_LEVELS], group_log_chain[NOF_LEVELS],
                           dir_chain[NOF_LEVELS], mode_chain[NOF_LEVELS]};

endmodule

// File: tb/tb_pe_segmented_rotator.sv
// Directed bench for pe_segmented_rotator at default parameters.
`timescale 1ns/1ps
module tb_pe_segmented_rotator;

    localparam int unsigned WORD_SIZE        = 256;
    localparam int unsigned NOF_PES          = 16;
    localparam int unsigned NOF_LEVELS       = 4;
    localparam int unsigned GROUP_SIZE_WIDTH = 5;
    localparam int unsigned TAG_WIDTH        = 8;
    localparam int unsigned DATA_WIDTH       = WORD_SIZE * NOF_PES;

    logic                        clk;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH-1:0]       in;
    logic [NOF_LEVELS-1:0]       in_amt;
    logic [GROUP_SIZE_WIDTH-1:0] in_group_log;
    logic                        in_dir;
    logic                        in_mode;
    logic [TAG_WIDTH-1:0]        in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out;
    logic [TAG_WIDTH-1:0]        out_tag;

    int total = 0;
    int bad   = 0;
    int cyc;
    int sent;
    int recv;
    int occ;
    bit saw_block;
    bit acc;
    bit del;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pe_segmented_rotator #(
        .WORD_SIZE        (WORD_SIZE),
        .NOF_PES          (NOF_PES),
        .NOF_LEVELS       (NOF_LEVELS),
        .GROUP_SIZE_WIDTH (GROUP_SIZE_WIDTH),
        .TAG_WIDTH        (TAG_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in           (in),
        .in_amt       (in_amt),
        .in_group_log (in_group_log),
        .in_dir       (in_dir),
        .in_mode      (in_mode),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out          (out),
        .out_tag      (out_tag)
    );

    task automatic check(input string name, input logic [WORD_SIZE-1:0] got,
                         input logic [WORD_SIZE-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [WORD_SIZE-1:0] lane_of(input int p);
        return out[p*WORD_SIZE +: WORD_SIZE];
    endfunction

    // Present one transaction from a negedge; returns at the negedge after acceptance.
    task automatic send(input int amt, input int glog, input int dir, input int mode,
                        input int tag);
        bit ok;
        ok           = 1'b0;
        in_amt       = NOF_LEVELS'(amt);
        in_group_log = GROUP_SIZE_WIDTH'(glog);
        in_dir       = 1'(dir);
        in_mode      = 1'(mode);
        in_tag       = TAG_WIDTH'(tag);
        in_valid     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    // Cycles from acceptance until out_valid, 0 on timeout.
    task automatic wait_out(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int p = 0; p < NOF_PES; p++) in[p*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(p + 1);
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_amt       = '0;
        in_group_log = '0;
        in_dir       = 1'b0;
        in_mode      = 1'b0;
        in_tag       = '0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", |out, 0);
        check("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Rotate up by 3 across the full array.
        send(3, 4, 0, 0, 8'h5A);
        wait_out(cyc);
        check("rot_latency", cyc, 4);
        check("rot_tag", out_tag, 8'h5A);
        check("rot_lane0", lane_of(0), 14);
        check("rot_lane3", lane_of(3), 1);
        check("rot_lane15", lane_of(15), 13);

        // Zero-fill shift up by 1 in groups of 4.
        send(1, 2, 0, 1, 1);
        wait_out(cyc);
        check("shu_lane0", lane_of(0), 0);
        check("shu_lane4", lane_of(4), 0);
        check("shu_lane8", lane_of(8), 0);
        check("shu_lane12", lane_of(12), 0);
        check("shu_lane1", lane_of(1), 1);
        check("shu_lane5", lane_of(5), 5);
        check("shu_lane7", lane_of(7), 7);

        // Shift down, amount 5 reduces to 1 in groups of 4.
        send(5, 2, 1, 1, 2);
        wait_out(cyc);
        check("shd_lane3", lane_of(3), 0);
        check("shd_lane0", lane_of(0), 2);
        check("shd_lane14", lane_of(14), 16);

        // Oversized group_log saturates to the full array.
        send(15, 7, 1, 0, 3);
        wait_out(cyc);
        check("sat_lane0", lane_of(0), 16);
        check("sat_lane1", lane_of(1), 1);

        // Single-lane groups are identity.
        send(9, 0, 0, 1, 4);
        wait_out(cyc);
        check("id_lane0", lane_of(0), 1);
        check("id_lane9", lane_of(9), 10);
        check("id_lane15", lane_of(15), 16);
        @(negedge clk);

        // Back-to-back stream with a downstream stall on cycles 5..9.
        sent = 0; recv = 0; occ = 0; saw_block = 1'b0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            out_ready    = !(c >= 5 && c <= 9);
            in_valid     = (sent < 8);
            in_amt       = NOF_LEVELS'(sent);
            in_group_log = GROUP_SIZE_WIDTH'(4);
            in_dir       = 1'b0;
            in_mode      = 1'b0;
            in_tag       = TAG_WIDTH'(sent);
            #1;
            check("b2b_in_ready", in_ready, (occ == NOF_LEVELS && !out_ready) ? 0 : 1);
            if (!in_ready) saw_block = 1'b1;
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (out_valid) begin
                check("b2b_tag", out_tag, recv);
                check("b2b_lane0", lane_of(0), ((16 - recv) % 16) + 1);
            end
            @(posedge clk);
            if (acc) begin
                sent++;
                occ++;
            end
            if (del) begin
                occ--;
                recv++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("b2b_recv", recv, 8);
        check("b2b_sent", sent, 8);
        check("b2b_blocked", saw_block, 1);
        repeat (3) @(negedge clk);
        check("b2b_drained", out_valid, 0);

        // Reset with three transactions in flight.
        send(1, 4, 0, 0, 8'h10);
        send(1, 4, 0, 0, 8'h11);
        send(1, 4, 0, 0, 8'h12);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out", |out, 0);
        check("mid_rst_out_tag", out_tag, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2, 4, 1, 1, 8'h33);
        wait_out(cyc);
        check("post_rst_latency", cyc, 4);
        check("post_rst_tag", out_tag, 8'h33);
        check("post_rst_lane0", lane_of(0), 3);
        check("post_rst_lane13", lane_of(13), 16);
        check("post_rst_lane14", lane_of(14), 0);
        @(negedge clk);
        check("post_rst_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_segmented_rotator.md
# pe_segmented_rotator

Pipelined, parametrised successor to the PE-array barrel shifter. It moves NOF_PES words of WORD_SIZE bits between processing-element lanes. Each transaction carries its own shift amount, direction, mode (rotate or zero-fill shift) and segment size, so the array can be split into independent power-of-two groups. It uses one register stage per shift level, a valid/ready handshake on both sides, and a sideband tag. Sits between the PE array outputs and the interconnect return path.

## Interface
- WORD_SIZE, 256, bits per PE word
- NOF_PES, 16, lane count; must be a power of two ≥ 2
- NOF_LEVELS, $clog2(NOF_PES), shift levels and pipeline stages
- GROUP_SIZE_WIDTH, NOF_LEVELS+1, width of group_log field
- TAG_WIDTH, 8, sideband tag width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  transaction present
- in_ready  out  1  block accepts when in_valid && in_ready
- in  in  WORD_SIZE*NOF_PES  lane p occupies bits [p*WORD_SIZE +: WORD_SIZE]
- in_amt  in  NOF_LEVELS  shift distance in lanes
- in_group_log  in  GROUP_SIZE_WIDTH  group size G = 2^in_group_log
- in_dir  in  1  0 = toward higher lane index, 1 = toward lower
- in_mode  in  1  0 = rotate within group, 1 = shift with zero fill
- in_tag  in  TAG_WIDTH  carried unchanged to out_tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out  out  WORD_SIZE*NOF_PES  shifted vector
- out_tag  out  TAG_WIDTH  tag of current result

## Operation
- Group size saturation: a value of in_group_log above NOF_LEVELS is treated as NOF_LEVELS.
- Effective amount: a = in_amt & (G−1). The amount is reduced modulo G.
- Groups: lanes [kG, kG+G−1]. Data never crosses a group boundary.
- Rotate, dir 0: out[kG+j] = in[kG+((j−a) mod G)].
- Rotate, dir 1: out[kG+j] = in[kG+((j+a) mod G)].
- Shift, dir 0: out[kG+j] = in[kG+j−a] when j ≥ a, else 0.
- Shift, dir 1: out[kG+j] = in[kG+j+a] when j+a < G, else 0.
- Level implementation: level L moves by 2^L when bit L of a is set. Source index wraps inside the group. A zero-fill flag is set when the move crosses the group edge in shift mode.
- a = 0 or G = 1 gives identity in both modes.
- Control fields (a, G, dir, mode, tag) travel with the data through every stage.

## Timing
- Latency is NOF_LEVELS cycles from acceptance to out_valid, assuming no stall; 4 cycles at defaults.
- Throughput is one transaction per cycle.
- Stage s loads when its valid is low or stage s+1 is loading. The last stage loads when out_valid is low or out_ready is high.
- in_ready is stage 0's load condition. It is combinational from out_ready through the stage valids.
- Under stall (out_valid && !out_ready), out and out_tag hold stable. Bubbles between stages are collapsed.
- Reset values: all stage valids 0, in_ready 0 while rst_n low, out_valid 0, out 0, out_tag 0.
- Reset mid-operation discards every in-flight transaction. The first result after reset comes only from post-reset input.
- Simultaneous accept and output on the same cycle is legal at full occupancy; no transaction is lost or duplicated.

## Structure
- Package pe_shift_pkg holds:
  - DIR_UP/DIR_DOWN constants
  - MODE_ROTATE/MODE_SHIFT constants
  - a function that saturates group_log
  - a function that computes the source lane index and zero flag for a given level, lane, G and dir
- Sub-module pe_rotator_stage: one level. It takes the level index as a parameter and contains the permutation, the stage register and the valid/load logic. The top instantiates NOF_LEVELS of them in a generate loop and contains only the handshake chaining.

## Test plan
Defaults throughout; in lane p = p+1.
- Rotate, dir 0, amt 3, group_log 4 → out lane0 = 14, lane3 = 1, lane15 = 13. out_valid rises 4 cycles after acceptance; tag 0x5A appears on out_tag.
- Shift, dir 0, amt 1, group_log 2 → lanes {0,4,8,12} = 0, lane1 = 1, lane5 = 5, lane7 = 7.
- Shift, dir 1, amt 5, group_log 2 → amount reduces to 1: lane3 = 0, lane0 = 2, lane14 = 16.
- group_log 7, rotate, dir 1, amt 15 → saturates to G = 16: lane0 = 16, lane1 = 1. Separately, group_log 0 with any amount → identity.
- Back-to-back 8 transactions with tags 0..7 and out_ready held low for cycles 5–9:
  - in_ready drops once all 4 stages are full
  - out holds stable during the stall
  - results leave in order 0..7 with no loss or duplication
- rst_n low for 1 cycle with 3 transactions in flight → out_valid 0 and out 0 immediately. The next accepted transaction is the first observed result.
